dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port (addr/data/rw/id/valid in, data/id/ready out, stall out)
//  between two requesters: req0 = load/store queue, req1 = secondary client (debug/fill).
//  Round-robin arbitration; remaps each requester's 4-bit id onto a private memory tag.
//  Routes out-of-order memory responses back to the owning requester with its original id.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  data width
//  NTAG    16  memory tags; tag width fixed at 4 bits, NTAG <= 16
// PORTS
//  clk           in   1       clock, all state on posedge
//  rst           in   1       reset, asynchronous, active-high
//  reqN_valid    in   1       (N=0,1) request present; held until reqN_grant
//  reqN_rw       in   1       1=store, 0=load
//  reqN_addr     in   ADDR_W  byte address
//  reqN_data     in   DATA_W  store data
//  reqN_id       in   4       requester-local id
//  reqN_grant    out  1       combinational: request accepted this cycle
//  rspN_valid    out  1       registered: one-cycle response pulse
//  rspN_data     out  DATA_W  load data (0 for stores)
//  rspN_id       out  4       original requester id
//  mem_valid     out  1       registered request strobe to memory
//  mem_rw        out  1       registered
//  mem_addr      out  ADDR_W  registered
//  mem_data      out  DATA_W  registered
//  mem_id        out  4       allocated tag
//  mem_rdata     in   DATA_W  response data
//  mem_rid       in   4       response tag
//  mem_ready     in   1       response valid
//  mem_stall     in   1       memory cannot accept requests
//  outstanding   out  5       tags in use (registered)
//  err_spurious  out  1       sticky: response with tag not in use
// BEHAVIOUR
//  - Reset: all outputs 0, all tags free, rr pointer = 0, tag table cleared. Async reset
//    mid-transaction drops all in-flight tags; late responses then count as spurious.
//  - Grant (comb): eligible = !mem_stall && a free tag exists (as of cycle start).
//    Both valid: grant the rr pointer's requester; one valid: grant it. At most one grant/cycle.
//  - rr pointer: after a grant to requester k, pointer = 1-k. No grant -> unchanged.
//  - Allocation: lowest-numbered free tag; table[tag] <= {owner, reqN_id}, in_use set at edge.
//  - Issue latency: grant in cycle N -> mem_valid=1 with captured fields in cycle N+1.
//    mem_valid=0 in any cycle following a no-grant cycle; other mem_* fields hold.
//  - Response: mem_ready && in_use[mem_rid] in cycle M -> rsp{owner}_valid=1 in M+1 with
//    mem_rdata and stored id; the other rsp stays 0. Tag freed at the same edge; reusable
//    for grants from M+1.
//  - Same-cycle free and alloc: alloc uses cycle-start free mask; a tag freeing this cycle is
//    not reallocated until next cycle. outstanding += grant - valid_response, never wraps.
//  - mem_ready with !in_use[mem_rid]: no rsp pulse, no table change, err_spurious <= 1 until rst.
//  - Full (outstanding == NTAG): no grants; reqN_valid must hold. Stall overrides rr; pointer frozen.
//  - Responses are accepted even while mem_stall=1 or the table is full.
// TESTING
//  1 Single load req0 id=3 addr=0x8 -> grant0 same cycle; next cycle mem_valid=1, mem_id=0, mem_rw=0;
//    mem_ready rid=0 data=0x55 -> next cycle rsp0_valid=1, rsp0_id=3, rsp0_data=0x55.
//  2 req0, req1 both valid 4 cycles -> grants alternate 0,1,0,1; tags 0,1,2,3; outstanding=4.
//  3 mem_stall=1 with both valid -> no grant, mem_valid=0, pointer unchanged; stall drop -> grant0.
//  4 Issue 16 with no responses -> outstanding=16, grant held 0; respond tag 5 -> next grant gets tag 5.
//  5 Out-of-order: tags 0(req0 id 2), 1(req1 id 9); respond 1 then 0 -> rsp1 id 9, then rsp0 id 2.
//  6 mem_ready rid=7 unused -> err_spurious=1, no rsp; async rst mid-flight -> all outputs 0 immediately.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ==== dmem_port_arbiter : round-robin share of one tagged data-memory port between two ====
// ==== requesters, with out-of-order response routing through a tag table.   Rev 1.0    ====
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NTAG   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [3:0]        req0_id,
  output logic              req0_grant,
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [3:0]        req1_id,
  output logic              req1_grant,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic [3:0]        rsp0_id,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [3:0]        rsp1_id,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [3:0]        mem_id,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [3:0]        mem_rid,
  input  logic              mem_ready,
  input  logic              mem_stall,
  output logic [4:0]        outstanding,
  output logic              err_spurious
);

  logic [15:0] in_use;
  logic        tbl_owner [16];
  logic        tbl_rw    [16];
  logic [3:0]  tbl_id    [16];
  logic        rr;
  logic        any_free;
  logic [3:0]  alloc_tag;
  logic        eligible;
  logic        grant_any;
  logic        sel1;
  logic        rsp_hit;
  logic [15:0] set_mask;
  logic [15:0] clr_mask;

  // Descending scan leaves the lowest-numbered free tag selected.
  always_comb begin
    any_free  = 1'b0;
    alloc_tag = 4'd0;
    for (int i = NTAG - 1; i >= 0; i--) begin
      if (!in_use[i]) begin
        any_free  = 1'b1;
        alloc_tag = 4'(i);
      end
    end
  end

  assign eligible   = !mem_stall && any_free;
  assign req0_grant = eligible && req0_valid && (!req1_valid || !rr);
  assign req1_grant = eligible && req1_valid && (!req0_valid || rr);
  assign grant_any  = req0_grant | req1_grant;
  assign sel1       = req1_grant;
  assign rsp_hit    = mem_ready && in_use[mem_rid];
  assign set_mask   = 16'(grant_any) << alloc_tag;
  assign clr_mask   = 16'(rsp_hit) << mem_rid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_use       <= '0;
      rr           <= 1'b0;
      mem_valid    <= 1'b0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_id       <= '0;
      rsp0_valid   <= 1'b0;
      rsp0_data    <= '0;
      rsp0_id      <= '0;
      rsp1_valid   <= 1'b0;
      rsp1_data    <= '0;
      rsp1_id      <= '0;
      outstanding  <= '0;
      err_spurious <= 1'b0;
      for (int t = 0; t < 16; t++) begin
        tbl_owner[t] <= 1'b0;
        tbl_rw[t]    <= 1'b0;
        tbl_id[t]    <= '0;
      end
    end else begin
      mem_valid <= grant_any;
      if (grant_any) begin
        rr                <= req0_grant;
        mem_rw            <= sel1 ? req1_rw   : req0_rw;
        mem_addr          <= sel1 ? req1_addr : req0_addr;
        mem_data          <= sel1 ? req1_data : req0_data;
        mem_id            <= alloc_tag;
        tbl_owner[alloc_tag] <= sel1;
        tbl_rw[alloc_tag]    <= sel1 ? req1_rw : req0_rw;
        tbl_id[alloc_tag]    <= sel1 ? req1_id : req0_id;
      end
      // The allocated tag was free at cycle start, so it never collides with clr_mask.
      in_use      <= (in_use | set_mask) & ~clr_mask;
      outstanding <= outstanding + 5'(grant_any) - 5'(rsp_hit);
      rsp0_valid  <= rsp_hit && !tbl_owner[mem_rid];
      rsp1_valid  <= rsp_hit && tbl_owner[mem_rid];
      if (rsp_hit && !tbl_owner[mem_rid]) begin
        rsp0_data <= tbl_rw[mem_rid] ? '0 : mem_rdata;
        rsp0_id   <= tbl_id[mem_rid];
      end
      if (rsp_hit && tbl_owner[mem_rid]) begin
        rsp1_data <= tbl_rw[mem_rid] ? '0 : mem_rdata;
        rsp1_id   <= tbl_id[mem_rid];
      end
      if (mem_ready && !in_use[mem_rid]) err_spurious <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ==== tb_dmem_port_arbiter : scoreboard bench for dmem_port_arbiter, directed + random ====
// ==== Rev 1.0                                                                         ====
module tb_dmem_port_arbiter;
  localparam int NTAG = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_rw, req1_valid, req1_rw;
  logic [31:0] req0_addr, req0_data, req1_addr, req1_data;
  logic [3:0]  req0_id, req1_id;
  logic        req0_grant, req1_grant;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic [3:0]  rsp0_id, rsp1_id;
  logic        mem_valid, mem_rw;
  logic [31:0] mem_addr, mem_data;
  logic [3:0]  mem_id;
  logic [31:0] mem_rdata;
  logic [3:0]  mem_rid;
  logic        mem_ready, mem_stall;
  logic [4:0]  outstanding;
  logic        err_spurious;

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_id(req0_id), .req0_grant(req0_grant),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_id(req1_id), .req1_grant(req1_grant),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_id(rsp0_id),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_id(rsp1_id),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_id(mem_id), .mem_rdata(mem_rdata),
    .mem_rid(mem_rid), .mem_ready(mem_ready), .mem_stall(mem_stall),
    .outstanding(outstanding), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: which tags are live and who owns them.
  bit          m_use [NTAG];
  bit          m_own [NTAG];
  bit          m_rw  [NTAG];
  logic [3:0]  m_id  [NTAG];
  int          m_rr, m_out;
  bit          m_err;
  bit          exp_g0, exp_g1;

  logic [68:0] mem_q[$];
  logic [35:0] rsp0_q[$];
  logic [35:0] rsp1_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic clear_model();
    for (int t = 0; t < NTAG; t++) begin
      m_use[t] = 0; m_own[t] = 0; m_rw[t] = 0; m_id[t] = '0;
    end
    m_rr = 0; m_out = 0; m_err = 0;
    mem_q.delete(); rsp0_q.delete(); rsp1_q.delete();
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0; mem_stall = 0;
    mem_ready = 0; mem_rid = '0; mem_rdata = '0;
  endtask

  task automatic new_req(input int k);
    if (k == 0) begin
      req0_valid = 1; req0_rw = 1'($urandom); req0_addr = $urandom;
      req0_data = $urandom; req0_id = 4'($urandom);
    end else begin
      req1_valid = 1; req1_rw = 1'($urandom); req1_addr = $urandom;
      req1_data = $urandom; req1_id = 4'($urandom);
    end
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step();
    int g, tag;
    bit hit;
    logic [3:0] rid;
    #1;
    chk("outstanding", outstanding, m_out);
    chk("err_spurious", err_spurious, m_err);
    g = -1;
    if (!mem_stall && m_out < NTAG) begin
      if (req0_valid && req1_valid) g = m_rr;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
    end
    exp_g0 = (g == 0);
    exp_g1 = (g == 1);
    chk("grant0", req0_grant, exp_g0);
    chk("grant1", req1_grant, exp_g1);
    rid = mem_rid;
    hit = mem_ready && m_use[rid];
    if (mem_ready && !hit) m_err = 1;
    if (g >= 0) begin
      tag = 0;
      while (m_use[tag]) tag++;
      m_use[tag] = 1;
      m_own[tag] = (g == 1);
      m_rw[tag]  = (g == 1) ? req1_rw : req0_rw;
      m_id[tag]  = (g == 1) ? req1_id : req0_id;
      if (g == 1) mem_q.push_back({req1_rw, req1_addr, req1_data, 4'(tag)});
      else        mem_q.push_back({req0_rw, req0_addr, req0_data, 4'(tag)});
      m_rr = 1 - g;
      m_out++;
    end
    if (hit) begin
      if (m_own[rid]) rsp1_q.push_back({m_id[rid], m_rw[rid] ? 32'd0 : mem_rdata});
      else            rsp0_q.push_back({m_id[rid], m_rw[rid] ? 32'd0 : mem_rdata});
      m_use[rid] = 0;
      m_out--;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    #3 rst = 1;
    #1;
    chk("rst_outputs_zero", |{req0_grant, req1_grant, rsp0_valid, rsp0_data, rsp0_id,
        rsp1_valid, rsp1_data, rsp1_id, mem_valid, mem_rw, mem_addr, mem_data, mem_id,
        outstanding, err_spurious}, 0);
    clear_model();
    @(negedge clk);
    rst = 0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a request or a response.
  initial begin
    logic [68:0] em;
    logic [35:0] er;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (mem_valid) begin
          if (mem_q.size() == 0) chk("mem_unexpected", 1, 0);
          else begin
            em = mem_q.pop_front();
            chk("mem_rw", mem_rw, em[68]);
            chk("mem_addr", mem_addr, em[67:36]);
            chk("mem_data", mem_data, em[35:4]);
            chk("mem_id", mem_id, em[3:0]);
          end
        end else chk("mem_missing", mem_q.size(), 0);
        if (rsp0_valid) begin
          if (rsp0_q.size() == 0) chk("rsp0_unexpected", 1, 0);
          else begin
            er = rsp0_q.pop_front();
            chk("rsp0_id", rsp0_id, er[35:32]);
            chk("rsp0_data", rsp0_data, er[31:0]);
          end
        end else chk("rsp0_missing", rsp0_q.size(), 0);
        if (rsp1_valid) begin
          if (rsp1_q.size() == 0) chk("rsp1_unexpected", 1, 0);
          else begin
            er = rsp1_q.pop_front();
            chk("rsp1_id", rsp1_id, er[35:32]);
            chk("rsp1_data", rsp1_data, er[31:0]);
          end
        end else chk("rsp1_missing", rsp1_q.size(), 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tq[$];
    idle();
    req0_rw = 0; req0_addr = '0; req0_data = '0; req0_id = '0;
    req1_rw = 0; req1_addr = '0; req1_data = '0; req1_id = '0;
    rst = 1;
    clear_model();
    repeat (2) @(negedge clk);
    chk("reset_outputs", |{mem_valid, rsp0_valid, rsp1_valid, outstanding, err_spurious,
        mem_id, mem_addr}, 0);
    rst = 0;

    // Single load from req0, then its response.
    req0_valid = 1; req0_rw = 0; req0_addr = 32'h8; req0_data = 32'h0; req0_id = 4'd3;
    step();
    req0_valid = 0;
    chk("t1_mem_valid", mem_valid, 1);
    chk("t1_mem_id", mem_id, 0);
    chk("t1_mem_rw", mem_rw, 0);
    chk("t1_mem_addr", mem_addr, 32'h8);
    mem_ready = 1; mem_rid = 4'd0; mem_rdata = 32'h55;
    step();
    mem_ready = 0;
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_rsp0_id", rsp0_id, 3);
    chk("t1_rsp0_data", rsp0_data, 32'h55);
    chk("t1_rsp1_quiet", rsp1_valid, 0);
    step();

    // Both requesters continuously valid: alternation, then stall freezes everything.
    do_reset();
    new_req(0); new_req(1);
    for (int i = 0; i < 4; i++) begin
      step();
      if (exp_g0) new_req(0);
      if (exp_g1) new_req(1);
    end
    chk("t2_outstanding", outstanding, 4);
    mem_stall = 1;
    step(); step();
    chk("t3_stall_no_issue", mem_valid, 0);
    mem_stall = 0;
    step();
    chk("t3_after_stall_tag", mem_id, 4);
    req0_valid = 0; req1_valid = 0;

    // Fill every tag, hold at full, free tag 5 and watch it get reused.
    do_reset();
    for (int i = 0; i < NTAG; i++) begin
      new_req(0);
      step();
    end
    new_req(0);
    chk("t4_full", outstanding, 16);
    step(); step();
    mem_ready = 1; mem_rid = 4'd5; mem_rdata = 32'hA5A5_0005;
    step();
    mem_ready = 0;
    step();
    chk("t4_reuse_tag5", mem_id, 5);
    req0_valid = 0;

    // Out-of-order responses routed back to their owners.
    do_reset();
    req0_valid = 1; req0_rw = 0; req0_addr = 32'h100; req0_id = 4'd2;
    req1_valid = 1; req1_rw = 0; req1_addr = 32'h200; req1_id = 4'd9;
    step();
    step();
    req0_valid = 0; req1_valid = 0;
    mem_ready = 1; mem_rid = 4'd1; mem_rdata = 32'h1111;
    step();
    chk("t5_rsp1_id", rsp1_id, 9);
    mem_rid = 4'd0; mem_rdata = 32'h2222;
    step();
    chk("t5_rsp0_id", rsp0_id, 2);
    mem_ready = 0;
    step();

    // Spurious tag, then async reset with tags in flight and a late response.
    mem_ready = 1; mem_rid = 4'd7;
    step();
    mem_ready = 0;
    chk("t6_err", err_spurious, 1);
    new_req(0); new_req(1);
    step(); step();
    do_reset();
    mem_ready = 1; mem_rid = 4'd0; mem_rdata = 32'h77;
    step();
    mem_ready = 0;
    step();

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if (!req0_valid && $urandom_range(1, 0) == 1) new_req(0);
      if (!req1_valid && $urandom_range(1, 0) == 1) new_req(1);
      mem_stall = ($urandom_range(4, 0) == 0);
      mem_ready = 0;
      mem_rdata = $urandom;
      if ($urandom_range(9, 0) < 4) begin
        tq.delete();
        for (int t = 0; t < NTAG; t++) if (m_use[t]) tq.push_back(t);
        if ($urandom_range(29, 0) == 0) begin
          mem_ready = 1; mem_rid = 4'($urandom);
        end else if (tq.size() > 0) begin
          mem_ready = 1; mem_rid = 4'(tq[$urandom_range(tq.size() - 1, 0)]);
        end
      end
      step();
      if (exp_g0) req0_valid = 0;
      if (exp_g1) req1_valid = 0;
    end
    idle();
    repeat (3) step();
    chk("drain_mem_q", mem_q.size(), 0);
    chk("drain_rsp_q", rsp0_q.size() + rsp1_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
